// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
// Shared types and defaults for the filtered-RAM ping-pong scheduler.
package nabp_sched_pkg;
    localparam int kDefNoOfAngles  = 180;
    localparam int kDefAngleLength = 8;

    typedef logic bank_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_OVERLAP,
        ST_DRAIN,
        ST_SWAP
    } sched_state_t;

    function automatic logic [1:0] bank_onehot(input bank_t b);
        return b ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/nabp_filtered_ram_swap_control_if.sv
// Handshake bundle between host fill logic, RAM banks, processing and the scheduler.
interface nabp_filtered_ram_swap_control_if
    import nabp_sched_pkg::*;
    #(parameter int kAngleLength = kDefAngleLength) ();

    logic                    start;
    logic [1:0]              hs_fill_kick;
    logic [1:0]              hs_fill_done;
    logic [kAngleLength-1:0] fill_angle;
    logic                    pr_kick;
    logic                    pr_done;
    logic                    pr_bank_sel;
    logic [kAngleLength-1:0] pr_angle;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, hs_fill_done, pr_done,
        output hs_fill_kick, fill_angle, pr_kick, pr_bank_sel, pr_angle, busy, done
    );

    modport master (
        output start, hs_fill_done, pr_done,
        input  hs_fill_kick, fill_angle, pr_kick, pr_bank_sel, pr_angle, busy, done
    );
endinterface

// File: rtl/nabp_filtered_ram_swap_control_event_latch.sv
// Sticky completion flag: set by a pulse, cleared when the banks swap.
module nabp_event_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (set) q <= 1'b1;
    end
endmodule

// File: rtl/nabp_filtered_ram_swap_control.sv
// Ping-pong scheduler: fills one filtered-RAM bank while processing reads the other.
module nabp_filtered_ram_swap_control
    import nabp_sched_pkg::*;
    #(parameter int kNoOfAngles  = kDefNoOfAngles,
      parameter int kAngleLength = kDefAngleLength)
    (
    input  logic clk,
    input  logic reset,
    nabp_filtered_ram_swap_control_if.slave bus
);
    localparam logic [kAngleLength-1:0] LAST = kAngleLength'(kNoOfAngles - 1);

    sched_state_t            state, state_n;
    bank_t                   fill_bank, fill_bank_n, proc_bank, proc_bank_n;
    logic [kAngleLength-1:0] fill_angle, fill_angle_n, pr_angle, pr_angle_n;
    logic [1:0]              kick, kick_n;
    logic                    pr_kick, pr_kick_n, busy, busy_n, done, done_n;
    logic                    fill_ok, proc_ok, fill_set, proc_set, swap;

    // Completion events only count while both sides are in flight.
    assign fill_set = (state == ST_OVERLAP) && bus.hs_fill_done[fill_bank];
    assign proc_set = (state == ST_OVERLAP) && bus.pr_done;

    nabp_event_latch u_fill_ok (.clk(clk), .rst(reset), .set(fill_set), .clr(swap), .q(fill_ok));
    nabp_event_latch u_proc_ok (.clk(clk), .rst(reset), .set(proc_set), .clr(swap), .q(proc_ok));

    always_comb begin
        state_n      = state;
        fill_bank_n  = fill_bank;
        proc_bank_n  = proc_bank;
        fill_angle_n = fill_angle;
        pr_angle_n   = pr_angle;
        kick_n       = 2'b00;
        pr_kick_n    = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;
        swap         = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.start) begin
                state_n      = ST_FILL;
                fill_bank_n  = 1'b0;
                fill_angle_n = '0;
                kick_n       = bank_onehot(1'b0);
                busy_n       = 1'b1;
            end
            ST_FILL: if (bus.hs_fill_done[fill_bank]) state_n = ST_SWAP;
            ST_OVERLAP: if ((fill_ok || fill_set) && (proc_ok || proc_set)) state_n = ST_SWAP;
            ST_SWAP: begin
                swap        = 1'b1;
                proc_bank_n = fill_bank;
                pr_angle_n  = fill_angle;
                pr_kick_n   = 1'b1;
                if (fill_angle < LAST) begin
                    fill_bank_n  = ~fill_bank;
                    fill_angle_n = fill_angle + 1'b1;
                    kick_n       = bank_onehot(~fill_bank);
                    state_n      = ST_OVERLAP;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: if (bus.pr_done) begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            fill_bank  <= 1'b0;
            proc_bank  <= 1'b0;
            fill_angle <= '0;
            pr_angle   <= '0;
            kick       <= 2'b00;
            pr_kick    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            fill_bank  <= fill_bank_n;
            proc_bank  <= proc_bank_n;
            fill_angle <= fill_angle_n;
            pr_angle   <= pr_angle_n;
            kick       <= kick_n;
            pr_kick    <= pr_kick_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    assign bus.hs_fill_kick = kick;
    assign bus.fill_angle   = fill_angle;
    assign bus.pr_kick      = pr_kick;
    assign bus.pr_bank_sel  = proc_bank;
    assign bus.pr_angle     = pr_angle;
    assign bus.busy         = busy;
    assign bus.done         = done;
endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Randomized bench for the ping-pong scheduler against an angle/bank/timing reference model.
module tb_nabp_filtered_ram_swap_control;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    nabp_filtered_ram_swap_control_if #(.kAngleLength(8)) s  ();
    nabp_filtered_ram_swap_control_if #(.kAngleLength(8)) s1 ();

    nabp_filtered_ram_swap_control #(.kNoOfAngles(N), .kAngleLength(8)) dut (
        .clk(clk), .reset(rst), .bus(s.slave));
    nabp_filtered_ram_swap_control #(.kNoOfAngles(1), .kAngleLength(8)) dut1 (
        .clk(clk), .reset(rst), .bus(s1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] kick, input logic prk,
                            input logic sel, input logic [7:0] fa, input logic [7:0] pa,
                            input logic bsy, input logic dn);
        chk({tag, ".kick"}, kick, 0);
        chk({tag, ".pr_kick"}, prk, 0);
        chk({tag, ".sel"}, sel, 0);
        chk({tag, ".fill_angle"}, fa, 0);
        chk({tag, ".pr_angle"}, pa, 0);
        chk({tag, ".busy"}, bsy, 0);
        chk({tag, ".done"}, dn, 0);
    endtask

    // Expected behaviour: angle a is filled into bank a%2 and processed from bank a%2;
    // processing of angle a starts 2 cycles after both fill(a) and proc(a-1) have completed.
    task automatic run(input int df_lo, input int df_hi, input int dp_lo, input int dp_hi,
                       input bit noise, input int abort_at);
        int c, fk_n, pk_n, fcnt, pcnt, t_fd, t_pd, t_pk, texp;
        logic fbank;
        logic [1:0] fd;
        bit fin, aborted;
        c = 0; fk_n = 0; pk_n = 0; fcnt = -1; pcnt = -1;
        t_fd = 0; t_pd = 0; t_pk = 0; fbank = 1'b0; fin = 0; aborted = 0;
        @(negedge clk);
        s.start = 1'b1;
        while (!fin && !aborted) begin
            @(negedge clk);
            c++;
            s.start = 1'b0; s.pr_done = 1'b0; fd = 2'b00;
            if (c == 1) begin
                chk("busy_after_start", s.busy, 1);
                chk("kick_after_start", s.hs_fill_kick, 1);
            end
            if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) begin fd[fbank] = 1'b1; t_fd = c; fcnt = -1; end
            end
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) begin s.pr_done = 1'b1; t_pd = c; pcnt = -1; end
            end
            if (s.hs_fill_kick != 2'b00) begin
                chk("fk_bank", s.hs_fill_kick, (fk_n % 2) ? 2 : 1);
                chk("fk_angle", s.fill_angle, fk_n);
                if (fk_n > 0) chk("fk_with_pk", s.pr_kick, 1);
                fbank = s.hs_fill_kick[1];
                fk_n++;
                fcnt = $urandom_range(df_hi, df_lo);
            end
            if (s.pr_kick) begin
                texp = (pk_n == 0) ? t_fd + 2 : ((t_fd > t_pd) ? t_fd : t_pd) + 2;
                chk("pk_time", c, texp);
                chk("pk_bank", s.pr_bank_sel, pk_n % 2);
                chk("pk_angle", s.pr_angle, pk_n);
                pk_n++;
                t_pk = c;
                pcnt = $urandom_range(dp_hi, dp_lo);
            end else if (pk_n > 0) begin
                chk("sel_stable", s.pr_bank_sel, (pk_n - 1) % 2);
            end
            if (s.done) begin
                chk("done_time", c, t_pd + 1);
                chk("done_busy", s.busy, 0);
                chk("done_pk_n", pk_n, N);
                chk("done_fk_n", fk_n, N);
                fin = 1;
            end
            if (noise && !fin) begin
                if (fk_n > 0 && $urandom_range(5, 0) == 0) fd[~fbank] = 1'b1;
                if (pcnt < 0 && $urandom_range(5, 0) == 0) s.pr_done = 1'b1;
                if ($urandom_range(7, 0) == 0) s.start = 1'b1;
            end
            s.hs_fill_done = fd;
            if (abort_at > 0 && pk_n == abort_at && c == t_pk + 3) begin
                #2 rst = 1'b1;
                #1;
                chk_idle("async_rst", s.hs_fill_kick, s.pr_kick, s.pr_bank_sel,
                         s.fill_angle, s.pr_angle, s.busy, s.done);
                @(negedge clk);
                s.start = 1'b0; s.hs_fill_done = 2'b00; s.pr_done = 1'b0;
                rst = 1'b0;
                aborted = 1;
            end
            if (c > 4000) begin
                chk("timeout", 1, 0);
                fin = 1;
            end
        end
        s.hs_fill_done = 2'b00; s.pr_done = 1'b0;
        if (aborted) begin
            repeat (5) begin
                @(negedge clk);
                chk("no_done_after_rst", s.done, 0);
            end
        end else begin
            @(negedge clk);
            chk("done_one_cycle", s.done, 0);
            chk("idle_busy", s.busy, 0);
        end
    endtask

    initial begin
        int k1, p1, d1;
        s.start = 1'b0;  s.hs_fill_done = 2'b00;  s.pr_done = 1'b0;
        s1.start = 1'b0; s1.hs_fill_done = 2'b00; s1.pr_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst", s.hs_fill_kick, s.pr_kick, s.pr_bank_sel, s.fill_angle,
                 s.pr_angle, s.busy, s.done);
        chk_idle("rst1", s1.hs_fill_kick, s1.pr_kick, s1.pr_bank_sel, s1.fill_angle,
                 s1.pr_angle, s1.busy, s1.done);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(20, 20, 30, 30, 0, 0);
        run(25, 25, 25, 25, 0, 0);
        repeat (4) run(1, 40, 1, 40, 1, 0);
        run(20, 20, 30, 30, 0, 1);
        run(5, 10, 5, 10, 1, 0);

        // Single-angle run: no second fill kick, done right after pr_done.
        k1 = 0; p1 = 0; d1 = 0;
        @(negedge clk);
        s1.start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            s1.start = 1'b0; s1.hs_fill_done = 2'b00; s1.pr_done = 1'b0;
            if (s1.hs_fill_kick != 2'b00) begin
                k1++;
                chk("n1_fk", s1.hs_fill_kick, 1);
                chk("n1_fk_time", i, 1);
            end
            if (s1.pr_kick) begin
                p1++;
                chk("n1_pk_time", i, 6);
                chk("n1_pk_sel", s1.pr_bank_sel, 0);
                chk("n1_pk_angle", s1.pr_angle, 0);
            end
            if (s1.done) begin
                d1++;
                chk("n1_done_time", i, 11);
                chk("n1_done_busy", s1.busy, 0);
            end
            if (i == 4)  s1.hs_fill_done = 2'b01;
            if (i == 10) s1.pr_done = 1'b1;
        end
        chk("n1_fk_count", k1, 1);
        chk("n1_pk_count", p1, 1);
        chk("n1_done_count", d1, 1);
        chk("n1_fill_angle", s1.fill_angle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
